// File: rtl/pc_sequencer.sv
// Program-counter sequencer with sequential advance, branch, and a circular return-address stack.
// One action per cycle: rst > stall > ret > call > branch > sequential; all outputs registered.
module pc_sequencer #(
  parameter int unsigned       WIDTH       = 32,
  parameter int unsigned       STEP        = 4,
  parameter logic [WIDTH-1:0]  RESET_ADDR  = '0,
  parameter int unsigned       STACK_DEPTH = 4,
  localparam int unsigned      CW          = $clog2(STACK_DEPTH + 1),
  localparam int unsigned      PW          = $clog2(STACK_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] pc_out,
  output logic [CW-1:0]    stack_count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    wp_q, wp_d, wp_inc, wp_dec;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];

  assign pc_inc = pc_q + WIDTH'(STEP);
  // wp_q is the next write slot; a full push overwrites the oldest entry naturally.
  assign wp_inc = (wp_q == PW'(STACK_DEPTH - 1)) ? '0 : wp_q + 1'b1;
  assign wp_dec = (wp_q == '0) ? PW'(STACK_DEPTH - 1) : wp_q - 1'b1;

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    wp_d  = wp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (!stall) begin
      if (ret_en) begin
        if (cnt_q != '0) begin
          pc_d  = stack_q[wp_dec];
          wp_d  = wp_dec;
          cnt_d = cnt_q - 1'b1;
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (call_en) begin
        push = 1'b1;
        pc_d = branch_target;
        wp_d = wp_inc;
        if (cnt_q == CW'(STACK_DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (branch_en) begin
        pc_d = branch_target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_ADDR;
      cnt_q <= '0;
      wp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push) begin
        stack_q[wp_q] <= pc_inc;
      end
    end
  end

  assign pc_out      = pc_q;
  assign stack_count = cnt_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule
